// File: rtl/aes_word_flow_ctrl.sv
// AES round word-flow controller: streams ShiftRows-permuted columns through an external
// combinational round datapath, ping-ponging the state between two four-word banks.
module aes_word_flow_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*WORD_WIDTH-1:0] block_data_in,
    input  logic                    block_data_in_vld,
    input  logic                    dec_mode,
    input  logic                    key_available,
    output logic                    data_accept,
    output logic                    rnd_key_gen,
    output logic [WORD_WIDTH-1:0]   word_out_comb,
    output logic                    word_out_comb_vld,
    input  logic [WORD_WIDTH-1:0]   word_in_comb,
    output logic                    mix_column_off,
    output logic [4*WORD_WIDTH-1:0] data_out,
    output logic                    data_out_vld,
    input  logic                    data_out_rdy
);
    localparam int unsigned BLOCK_W = 4 * WORD_WIDTH;
    localparam int unsigned LANE_W  = WORD_WIDTH / 4;
    localparam int unsigned RND_W   = $clog2(NUM_ROUNDS + 1);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t                r_state;
    state_t                w_state_d;
    logic [WORD_WIDTH-1:0] r_bank_a [4];
    logic [WORD_WIDTH-1:0] r_bank_b [4];
    logic                  r_sel_b;
    logic                  r_dec;
    logic [1:0]            r_col;
    logic [RND_W-1:0]      r_round;
    logic [BLOCK_W-1:0]    r_data_out;
    logic                  r_out_vld;

    logic                  w_step;
    logic                  w_take;
    logic                  w_last;
    logic [LANE_W-1:0]     w_lane [4];
    logic [WORD_WIDTH-1:0] w_inact [4];
    logic [WORD_WIDTH-1:0] w_perm;

    // Lane g of the outgoing column comes from word (col +/- g) of the active bank.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [1:0]            w_src;
        logic [WORD_WIDTH-1:0] w_src_word;
        assign w_src      = r_dec ? (r_col - 2'(g)) : (r_col + 2'(g));
        assign w_src_word = r_sel_b ? r_bank_b[w_src] : r_bank_a[w_src];
        assign w_lane[g]  = w_src_word[WORD_WIDTH-1-g*LANE_W -: LANE_W];
        assign w_inact[g] = r_sel_b ? r_bank_a[g] : r_bank_b[g];
    end

    assign w_perm = {w_lane[0], w_lane[1], w_lane[2], w_lane[3]};

    assign w_step      = (r_state == StRun) && key_available;
    assign w_last      = w_step && (r_col == 2'd3) && (r_round == LAST_RND);
    assign data_accept = key_available &&
                         ((r_state == StIdle) || ((r_state == StDone) && data_out_rdy));
    assign w_take      = data_accept && block_data_in_vld;

    assign word_out_comb_vld = w_step;
    assign rnd_key_gen       = w_step;
    assign word_out_comb     = w_step ? w_perm : '0;
    assign mix_column_off    = w_step && (r_round == LAST_RND);
    assign data_out          = r_data_out;
    assign data_out_vld      = r_out_vld;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_take) w_state_d = StRun;
            StRun:   if (w_last) w_state_d = StDone;
            StDone: begin
                if (w_take)            w_state_d = StRun;
                else if (data_out_rdy) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_sel_b    <= 1'b0;
            r_dec      <= 1'b0;
            r_col      <= 2'd0;
            r_round    <= '0;
            r_data_out <= '0;
            r_out_vld  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_bank_a[i] <= '0;
                r_bank_b[i] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            if (w_take) begin
                for (int i = 0; i < 4; i++) begin
                    r_bank_a[i] <= block_data_in[BLOCK_W-1-i*WORD_WIDTH -: WORD_WIDTH];
                end
                r_dec   <= dec_mode;
                r_col   <= 2'd0;
                r_round <= RND_W'(1);
                r_sel_b <= 1'b0;
            end else if (w_step) begin
                if (r_sel_b) r_bank_a[r_col] <= word_in_comb;
                else         r_bank_b[r_col] <= word_in_comb;
                r_col <= r_col + 2'd1;
                if (r_col == 2'd3) begin
                    r_sel_b <= ~r_sel_b;
                    r_round <= r_round + RND_W'(1);
                end
            end
            // Final column is still in flight, so take it straight from the datapath.
            if (w_last) begin
                r_data_out <= {w_inact[0], w_inact[1], w_inact[2], word_in_comb};
                r_out_vld  <= 1'b1;
            end else if ((r_state == StDone) && data_out_rdy) begin
                r_out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_word_flow_ctrl.sv
// Bench for aes_word_flow_ctrl: block-level reference model checked every cycle, plus
// hand-computed ShiftRows results, latencies and handshake corner cases.
module tb_aes_word_flow_ctrl;
    localparam int unsigned NR = 10;
    localparam logic [127:0] BLK_A  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RES_A  = 128'h0009020b040d060f08010a030c050e07;
    localparam logic [127:0] BLK_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RES_B  = 128'h009922bb44dd66ff8811aa33cc55ee77;
    localparam logic [127:0] JUNK   = 128'hdeadbeefcafef00d0123456789abcdef;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] block_data_in = '0;
    logic         block_data_in_vld = 1'b0;
    logic         dec_mode = 1'b0;
    logic         key_available = 1'b1;
    logic         data_out_rdy = 1'b0;
    logic [31:0]  dp_k = '0;
    logic         data_accept, rnd_key_gen, word_out_comb_vld, mix_column_off, data_out_vld;
    logic [31:0]  word_out_comb, word_in_comb;
    logic [127:0] data_out;

    logic [127:0] t_bin = '0;
    logic         t_vld = 1'b0;
    logic         t_accept, t_keygen, t_wvld, t_mco, t_out_vld;
    logic [31:0]  t_word;
    logic [127:0] t_out;

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;

    assign word_in_comb = word_out_comb + dp_k;

    aes_word_flow_ctrl #(.NUM_ROUNDS(NR), .WORD_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .block_data_in(block_data_in),
        .block_data_in_vld(block_data_in_vld), .dec_mode(dec_mode),
        .key_available(key_available), .data_accept(data_accept), .rnd_key_gen(rnd_key_gen),
        .word_out_comb(word_out_comb), .word_out_comb_vld(word_out_comb_vld),
        .word_in_comb(word_in_comb), .mix_column_off(mix_column_off), .data_out(data_out),
        .data_out_vld(data_out_vld), .data_out_rdy(data_out_rdy)
    );

    aes_word_flow_ctrl #(.NUM_ROUNDS(12), .WORD_WIDTH(32)) u_dut12 (
        .clk(clk), .reset(reset), .block_data_in(t_bin), .block_data_in_vld(t_vld),
        .dec_mode(1'b0), .key_available(1'b1), .data_accept(t_accept), .rnd_key_gen(t_keygen),
        .word_out_comb(t_word), .word_out_comb_vld(t_wvld), .word_in_comb(t_word),
        .mix_column_off(t_mco), .data_out(t_out), .data_out_vld(t_out_vld),
        .data_out_rdy(1'b0)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference model: one block = NR rounds of (per-column ShiftRows gather, datapath).
    logic [127:0] m_cur = '0, m_nxt = '0, m_out = '0;
    bit           m_run = 1'b0, m_vld = 1'b0, m_dec = 1'b0;
    int           m_step = 0;

    function automatic logic [31:0] col_perm(input logic [127:0] b, input int c, input bit d);
        logic [31:0] w;
        for (int r = 0; r < 4; r++) begin
            int s;
            s = d ? (c - r + 4) % 4 : (c + r) % 4;
            w[31-8*r -: 8] = b[127-32*s-8*r -: 8];
        end
        return w;
    endfunction

    task automatic model_step();
        bit          acc;
        int          c;
        logic [31:0] w;
        if (reset) begin
            m_run = 0; m_vld = 0; m_dec = 0; m_step = 0;
            m_cur = '0; m_nxt = '0; m_out = '0;
        end else begin
            acc = key_available && block_data_in_vld &&
                  ((!m_run && !m_vld) || (m_vld && data_out_rdy));
            if (m_run && key_available) begin
                c = m_step % 4;
                w = col_perm(m_cur, c, m_dec) + dp_k;
                m_nxt[127-32*c -: 32] = w;
                m_step++;
                if (m_step % 4 == 0) m_cur = m_nxt;
                if (m_step == 4 * NR) begin
                    m_run = 0;
                    m_vld = 1;
                    m_out = m_nxt;
                end
            end else if (m_vld && data_out_rdy) begin
                m_vld = 0;
            end
            if (acc) begin
                m_cur = block_data_in; m_dec = dec_mode; m_step = 0; m_run = 1;
            end
        end
    endtask

    task automatic compare_now();
        bit          e_step, e_acc;
        logic [31:0] e_word;
        e_step = m_run && key_available;
        e_acc  = key_available && ((!m_run && !m_vld) || (m_vld && data_out_rdy));
        e_word = e_step ? col_perm(m_cur, m_step % 4, m_dec) : 32'h0;
        check("cyc_accept", 128'(data_accept), 128'(e_acc));
        check("cyc_word_vld", 128'(word_out_comb_vld), 128'(e_step));
        check("cyc_key_gen", 128'(rnd_key_gen), 128'(e_step));
        check("cyc_word", 128'(word_out_comb), 128'(e_word));
        check("cyc_mco", 128'(mix_column_off), 128'(e_step && (m_step / 4 == int'(NR) - 1)));
        check("cyc_out_vld", 128'(data_out_vld), 128'(m_vld));
        check("cyc_data_out", data_out, m_out);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        compare_now();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic offer(input logic [127:0] b, input bit d, output int t_acc);
        block_data_in = b;
        dec_mode = d;
        block_data_in_vld = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data_accept) begin
                t_acc = cyc;
                break;
            end
        end
        if (t_acc < 0) fail_now("accept_wait");
        @(posedge clk);
        #1;
        block_data_in_vld = 1'b0;
    endtask

    task automatic wait_vld(output int t_v);
        t_v = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (data_out_vld) begin
                t_v = cyc;
                break;
            end
        end
        if (t_v < 0) fail_now("out_vld_wait");
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        data_out_rdy = 1'b1;
        realign();
        data_out_rdy = 1'b0;
    endtask

    initial begin
        int ta, tv, nmco;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_vld", 128'(data_out_vld), 128'(0));
        check("rst_word_vld", 128'(word_out_comb_vld), 128'(0));
        check("rst_data_out", data_out, 128'(0));
        check("rst_accept", 128'(data_accept), 128'(1));
        realign();
        reset = 1'b0;

        // Encrypt, identity datapath; junk offered mid-run must be ignored.
        offer(BLK_A, 1'b0, ta);
        @(negedge clk);
        check("enc_first_word", 128'(word_out_comb), 128'h00050a0f);
        realign();
        block_data_in = JUNK;
        block_data_in_vld = 1'b1;
        repeat (10) realign();
        block_data_in_vld = 1'b0;
        wait_vld(tv);
        check("enc_latency", 128'(tv - ta), 128'(41));
        check("enc_data", data_out, RES_A);
        realign();
        drain();

        // Decrypt.
        offer(BLK_A, 1'b1, ta);
        @(negedge clk);
        check("dec_first_word", 128'(word_out_comb), 128'h000d0a07);
        wait_vld(tv);
        check("dec_data", data_out, RES_A);
        realign();
        drain();

        // Three-cycle key stall mid-run.
        offer(BLK_A, 1'b0, ta);
        repeat (9) realign();
        key_available = 1'b0;
        repeat (3) realign();
        key_available = 1'b1;
        wait_vld(tv);
        check("stall_latency", 128'(tv - ta), 128'(44));
        check("stall_data", data_out, RES_A);
        realign();

        // Back-pressure in DONE, then back-to-back handoff.
        repeat (5) begin
            @(negedge clk);
            check("hold_data", data_out, RES_A);
            check("hold_vld", 128'(data_out_vld), 128'(1));
        end
        realign();
        block_data_in = BLK_B;
        block_data_in_vld = 1'b1;
        data_out_rdy = 1'b1;
        @(negedge clk);
        check("handoff_accept", 128'(data_accept), 128'(1));
        realign();
        block_data_in_vld = 1'b0;
        data_out_rdy = 1'b0;
        @(negedge clk);
        check("handoff_no_idle", 128'(word_out_comb_vld), 128'(1));
        check("handoff_word", 128'(word_out_comb), 128'h0055aaff);
        wait_vld(tv);
        check("b2b_data", data_out, RES_B);
        realign();
        drain();

        // Non-identity datapath, decrypt; result comes from the model only.
        dp_k = 32'h01010101;
        offer(BLK_B, 1'b1, ta);
        wait_vld(tv);
        check("dp_data", data_out, m_out);
        realign();
        drain();
        dp_k = 32'h0;

        // Reset during step 17, then a clean block.
        offer(BLK_A, 1'b0, ta);
        repeat (16) @(posedge clk);
        #1;
        reset = 1'b1;
        realign();
        reset = 1'b0;
        @(negedge clk);
        check("mrst_out_vld", 128'(data_out_vld), 128'(0));
        check("mrst_word_vld", 128'(word_out_comb_vld), 128'(0));
        check("mrst_word", 128'(word_out_comb), 128'(0));
        check("mrst_key_gen", 128'(rnd_key_gen), 128'(0));
        check("mrst_mco", 128'(mix_column_off), 128'(0));
        check("mrst_data_out", data_out, 128'(0));
        realign();
        offer(BLK_A, 1'b0, ta);
        wait_vld(tv);
        check("post_rst_latency", 128'(tv - ta), 128'(41));
        check("post_rst_data", data_out, RES_A);
        realign();
        drain();

        // Twelve-round instance: ShiftRows^12 is the identity.
        t_bin = BLK_A;
        t_vld = 1'b1;
        ta = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (t_accept) begin
                ta = cyc;
                break;
            end
        end
        if (ta < 0) fail_now("r12_accept_wait");
        realign();
        t_vld = 1'b0;
        nmco = 0;
        tv = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (t_mco) nmco++;
            if (t_out_vld) begin
                tv = cyc;
                break;
            end
        end
        if (tv < 0) fail_now("r12_out_vld_wait");
        check("r12_latency", 128'(tv - ta), 128'(49));
        check("r12_data", t_out, BLK_A);
        check("r12_mco_cycles", 128'(nmco), 128'(4));
        realign();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_word_flow_ctrl.md
AES_WORD_FLOW_CTRL -- requirements
Module: aes_word_flow_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, giving rounds per block; legal values are 10, 12 and 14.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, giving the column word width; BLOCK width is fixed at 4*WORD_WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port block_data_in, input, 4*WORD_WIDTH, plaintext/ciphertext block; word 0 is the MS word and byte 0 is the MS byte of each word.
REQ-006 SHALL have port block_data_in_vld, input, 1, block offer qualifier.
REQ-007 SHALL have port dec_mode, input, 1, selecting inverse ShiftRows when high; it is sampled with the accepted block.
REQ-008 SHALL have port key_available, input, 1, indicating that key expansion can supply a round-key word this cycle.
REQ-009 SHALL have port data_accept, output, 1, indicating the block is taken when it is high together with block_data_in_vld.
REQ-010 SHALL have port rnd_key_gen, output, 1, requesting the next round-key word.
REQ-011 SHALL have port word_out_comb, output, WORD_WIDTH, the ShiftRows-permuted column sent to the round datapath.
REQ-012 SHALL have port word_out_comb_vld, output, 1, qualifying word_out_comb.
REQ-013 SHALL have port word_in_comb, input, WORD_WIDTH, the combinational datapath result for word_out_comb in the same cycle.
REQ-014 SHALL have port mix_column_off, output, 1, which bypasses MixColumns in the final round.
REQ-015 SHALL have port data_out, output, 4*WORD_WIDTH, the result block.
REQ-016 SHALL have port data_out_vld, output, 1, indicating the result is valid; it is held until taken.
REQ-017 SHALL have port data_out_rdy, input, 1, consumer ready; the transfer occurs when it is high together with data_out_vld.

Function
REQ-018 SHALL implement states IDLE, RUN and DONE.
REQ-019 SHALL drive data_accept = key_available && (IDLE || (DONE && data_out_rdy)).
REQ-020 On accept, SHALL load block_data_in into bank A, latch dec_mode, clear the word index (0..3) and set the round index to 1, then enter RUN.
REQ-021 In RUN, each cycle with key_available high SHALL assert word_out_comb_vld and rnd_key_gen and drive column c = word index of the active bank.
REQ-022 For a step, byte r of word_out_comb SHALL be taken from active-bank word (c+r) mod 4 when encrypting, or from word (c-r) mod 4 when dec_mode is high.
REQ-023 On each step, SHALL write word_in_comb into word c of the inactive bank and increment c.
REQ-024 When c wraps from 3 to 0, SHALL swap the active and inactive banks and increment the round index.
REQ-025 In RUN with key_available low, SHALL stall: word_out_comb_vld, rnd_key_gen and bank writes are held at 0, and the indices are held.
REQ-026 SHALL assert mix_column_off combinationally during every RUN step of round NUM_ROUNDS only.
REQ-027 After step 3 of round NUM_ROUNDS, SHALL enter DONE with data_out set to the four words just written (word 0 in the MS position) and data_out_vld set to 1.
REQ-028 SHALL give a latency, with no stalls, from the accept edge T to data_out_vld high of T+4*NUM_ROUNDS+1 cycles (41 for NUM_ROUNDS=10).
REQ-029 In DONE, when data_out_rdy is high and there is no accept, SHALL clear data_out_vld and go to IDLE next cycle; when an accept occurs in the same cycle, SHALL go directly to RUN (back-to-back).
REQ-030 SHALL ignore block_data_in_vld while data_accept is low; data_out and its contents are not disturbed.
REQ-031 SHALL hold data_out stable while data_out_vld is high and data_out_rdy is low.
REQ-032 SHALL drive word_out_comb to 0 whenever word_out_comb_vld is low.
REQ-033 SHALL size the round counter as clog2(NUM_ROUNDS+1) bits; the initial AddRoundKey is performed outside this block.

Reset
REQ-034 On reset high at a clock edge, SHALL enter IDLE from any state, including mid-RUN, and discard the block in progress.
REQ-035 After reset, SHALL hold data_out_vld, word_out_comb_vld, rnd_key_gen and mix_column_off at 0, data_out and both banks at 0, and data_accept equal to key_available.

Verification
REQ-036 With an identity datapath (word_in_comb = word_out_comb), NUM_ROUNDS=10, encrypt, input 000102030405060708090a0b0c0d0e0f: data_out SHALL be 0009020b040d060f08010a030c050e07 at T+41, and the first word_out_comb SHALL be 00050a0f at T+1.
REQ-037 With the same stimulus and dec_mode=1: the first word_out_comb SHALL be 000d0a07, and data_out SHALL be 0009020b040d060f08010a030c050e07.
REQ-038 With NUM_ROUNDS=12 and the identity datapath: data_out SHALL equal the input at T+49, and mix_column_off SHALL be high for exactly 4 cycles.
REQ-039 With key_available dropped for 3 cycles mid-RUN: data_out_vld SHALL rise exactly 3 cycles later than in REQ-036, with identical data.
REQ-040 With data_out_rdy held low for 5 cycles in DONE and then raised together with a new valid block: data_out SHALL be stable throughout, and the new block SHALL be accepted in the handoff cycle with no IDLE cycle.
REQ-041 With reset asserted at step 17 of a block: all outputs SHALL be 0 next cycle, and a following block SHALL complete with the correct REQ-036 result.
